dpsram_rd_stream: RTL and testbench

//  Read-side initiator for the team dual-port SRAM (1-cycle registered read, ren/raddr/rdata).

---
 rtl/dpsram_rd_stream_if.sv | 28 ++
 rtl/dpsram_rd_stream.sv | 142 ++++++++++++++
 tb/tb_dpsram_rd_stream.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpsram_rd_stream_if.sv
// Burst command and read-data stream bundle for dpsram_rd_stream.
// The DUT sits on the slave modport; the command source / stream sink sits on master.
interface dpsram_rd_stream_if #(
  parameter int A = 16,
  parameter int D = 32,
  parameter int L = 16
);
  // Handshake: a transfer happens on a posedge where valid && ready are both 1.
  // Once valid is raised it holds, with stable payload, until that transfer.
  logic         cmd_valid;
  logic         cmd_ready;
  logic [A-1:0] cmd_addr;
  logic [L-1:0] cmd_len;
  logic         out_valid;
  logic         out_ready;
  logic [D-1:0] out_data;
  logic         out_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dpsram_rd_stream.sv
// Burst read initiator for a 1-cycle-latency SRAM, streaming words through a 2-entry skid FIFO.
// Define DPSRAM_RD_ABORT_EN to add an abort input that cancels a burst in progress.
module dpsram_rd_stream #(
  parameter int A = 16,
  parameter int D = 32,
  parameter int L = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DPSRAM_RD_ABORT_EN
  input  logic             abort,
`endif
  dpsram_rd_stream_if.slave bus,
  output logic             busy,
  output logic             ren,
  output logic [A-1:0]     raddr,
  input  logic [D-1:0]     rdata,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_e;

  state_e       state_q, state_d;
  logic [A-1:0] addr_q, addr_d;
  logic [L:0]   remaining_q, remaining_d;
  logic         inflight_q, inflight_d;
  logic         inflight_last_q, inflight_last_d;
  logic [D:0]   fifo_q [2];
  logic [D:0]   fifo_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  logic       accept;
  logic       pop;
  logic       push;
  logic       flush;
  logic [2:0] occ_after;

`ifdef DPSRAM_RD_ABORT_EN
  assign flush = abort && (state_q != IDLE);
`else
  assign flush = 1'b0;
`endif

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = fifo_q[rd_ptr_q][D-1:0];
  assign bus.out_last  = bus.out_valid && fifo_q[rd_ptr_q][D];
  assign busy          = (state_q != IDLE);
  assign raddr         = addr_q;
  assign dbg_state     = state_q;

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign pop    = bus.out_valid && bus.out_ready;
  assign push   = inflight_q;

  // Words that will occupy the FIFO after this edge if nothing new is issued.
  assign occ_after = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
  assign ren       = (state_q == ISSUE) && (remaining_q != '0) && (occ_after < 3'd2) && !flush;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = ren;
    inflight_last_d = ren && (remaining_q == {{L{1'b0}}, 1'b1});
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ISSUE;
          addr_d      = bus.cmd_addr;
          remaining_d = {1'b0, bus.cmd_len} + {{L{1'b0}}, 1'b1};
        end
      end
      ISSUE: begin
        if (ren) begin
          addr_d      = addr_q + {{(A-1){1'b0}}, 1'b1};
          remaining_d = remaining_q - {{L{1'b0}}, 1'b1};
          if (remaining_q == {{L{1'b0}}, 1'b1}) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && bus.out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d    = IDLE;
      inflight_d = 1'b0;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {inflight_last_q, rdata};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    // Abort drops both queued words and the word still coming back from the SRAM.
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_q[0]       <= '0;
      fifo_q[1]       <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_q[0]       <= fifo_d[0];
      fifo_q[1]       <= fifo_d[1];
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == 2'd2)));

endmodule

// File: tb/tb_dpsram_rd_stream.sv
// Self-checking bench for dpsram_rd_stream: SRAM model, scoreboard on the output stream,
// issue-rule and address monitor, and one task per scenario.
module tb_dpsram_rd_stream;
  localparam int A = 16;
  localparam int D = 32;
  localparam int L = 16;

  logic         clk;
  logic         rst;
  logic         busy;
  logic         ren;
  logic [A-1:0] raddr;
  logic [D-1:0] rdata;
  logic [1:0]   dbg_state;
`ifdef DPSRAM_RD_ABORT_EN
  logic         abort;
`endif

  dpsram_rd_stream_if #(.A(A), .D(D), .L(L)) bus ();

  dpsram_rd_stream #(.A(A), .D(D), .L(L)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DPSRAM_RD_ABORT_EN
    .abort     (abort),
`endif
    .bus       (bus.slave),
    .busy      (busy),
    .ren       (ren),
    .raddr     (raddr),
    .rdata     (rdata),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: registered read, data valid the cycle after ren
  logic [D-1:0] mem [2**A];
  initial begin
    for (int i = 0; i < 2**A; i++) mem[i] = i;
  end
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  // Scoreboard state
  logic [D:0]   exp_q[$];
  int           vectors;
  int           miscompares;
  int           pop_cnt;
  int           outstanding;
  logic         mon_en;
  logic [A-1:0] exp_raddr;
  logic         stall_prev;
  logic [D-1:0] prev_data;
  logic         prev_last;

  always @(negedge clk) begin
    logic       pop;
    logic [D:0] exp;
    if (mon_en) begin
      pop = bus.out_valid && bus.out_ready;
      if (ren) begin
        vectors++;
        if (outstanding - int'(pop) >= 2) begin
          miscompares++;
          $display("FAIL issue_rule: ren=1 with %0d words pending, pop=%0d; required pending-pop < 2",
                   outstanding, pop);
        end
        vectors++;
        if (raddr !== exp_raddr) begin
          miscompares++;
          $display("FAIL raddr: got %h expected %h", raddr, exp_raddr);
        end
        exp_raddr = exp_raddr + 1'b1;
      end
      if (stall_prev) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_last !== prev_last) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                   bus.out_valid, bus.out_data, bus.out_last, prev_data, prev_last);
        end
      end
      if (pop) begin
        vectors++;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got data=%h last=%b expected no word", bus.out_data, bus.out_last);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== exp) begin
            miscompares++;
            $display("FAIL stream_word: got data=%h last=%b expected data=%h last=%b",
                     bus.out_data, bus.out_last, exp[D-1:0], exp[D]);
          end
        end
      end
      outstanding = outstanding + int'(ren) - int'(pop);
      stall_prev  = bus.out_valid && !bus.out_ready;
      prev_data   = bus.out_data;
      prev_last   = bus.out_last;
    end
  end

  // Driver tasks
  task automatic clear_model();
    exp_q.delete();
    outstanding = 0;
    stall_prev  = 1'b0;
  endtask

  task automatic send_cmd(input logic [A-1:0] a, input logic [L-1:0] n);
    logic [A-1:0] wa;
    logic         ok;
    for (int i = 0; i <= int'(n); i++) begin
      wa = a + i[A-1:0];
      exp_q.push_back({(i == int'(n)), mem[wa]});
    end
    exp_raddr = a;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = n;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL cmd_accept: got cmd_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin done = 1'b1; break; end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL burst_done: got busy=%b pending=%0d expected idle with 0 pending", busy, exp_q.size());
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.cmd_ready, bus.out_valid, bus.out_last, busy, ren} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b last=%b busy=%b ren=%b expected all 0",
               bus.cmd_ready, bus.out_valid, bus.out_last, busy, ren);
    end
    vectors++;
    if (raddr !== '0 || bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got raddr=%h out_data=%h expected 0 and 0", raddr, bus.out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: got cmd_ready=%b expected 1", bus.cmd_ready);
    end
    clear_model();
    mon_en = 1'b1;
  endtask

  task automatic test_basic_burst();
    int n;
    bus.out_ready = 1'b1;
    send_cmd(16'h0010, 16'd3);
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_accept: got cmd_ready=%b busy=%b expected 0 and 1", bus.cmd_ready, busy);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early1: got out_valid=%b expected 0", bus.out_valid);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early2: got out_valid=%b expected 0", bus.out_valid);
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL throughput: got %0d valid cycles of 4 expected 4", n);
    end
    wait_idle(20);
  endtask

  task automatic test_single_word();
    logic seen;
    bus.out_ready = 1'b1;
    send_cmd(16'h00FF, 16'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen || bus.out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL single_last: got valid=%b last=%b expected 1 and 1", seen, bus.out_last);
    end
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_after_pop: got cmd_ready=%b out_valid=%b expected 1 and 0",
               bus.cmd_ready, bus.out_valid);
    end
    wait_idle(10);
  endtask

  task automatic test_addr_wrap();
    bus.out_ready = 1'b1;
    send_cmd(16'hFFFE, 16'd3);
    wait_idle(20);
  endtask

  task automatic test_backpressure();
    logic pat [5];
    logic done;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0;
    send_cmd(16'h0040, 16'd7);
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      bus.out_ready = pat[k % 5];
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin done = 1'b1; break; end
      @(posedge clk); #1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL backpressure_done: got pending=%0d expected 0", exp_q.size());
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    bus.out_ready = 1'b1;
    send_cmd(16'h0100, 16'd15);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || ren !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got out_valid=%b busy=%b ren=%b expected 0 0 0", bus.out_valid, busy, ren);
    end
    clear_model();
    mon_en = 1'b1;
    send_cmd(16'h0200, 16'd5);
    wait_idle(30);
  endtask

`ifdef DPSRAM_RD_ABORT_EN
  task automatic test_abort();
    logic hit;
    bus.out_ready = 1'b1;
    pop_cnt = 0;
    send_cmd(16'h0300, 16'd9);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (pop_cnt >= 2) begin hit = 1'b1; break; end
    end
    #1;
    mon_en = 1'b0;
    abort  = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    vectors++;
    if (!hit || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: got reached=%b out_valid=%b out_last=%b busy=%b expected 1 0 0 0",
               hit, bus.out_valid, bus.out_last, busy);
    end
    clear_model();
    mon_en = 1'b1;
    send_cmd(16'h0400, 16'd1);
    wait_idle(20);
  endtask
`endif

  initial begin
    vectors       = 0;
    miscompares   = 0;
    pop_cnt       = 0;
    outstanding   = 0;
    mon_en        = 1'b0;
    stall_prev    = 1'b0;
    exp_raddr     = '0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
`ifdef DPSRAM_RD_ABORT_EN
    abort         = 1'b0;
`endif
    test_reset();
    test_basic_burst();
    test_single_word();
    test_addr_wrap();
    test_backpressure();
    test_reset_mid_burst();
`ifdef DPSRAM_RD_ABORT_EN
    test_abort();
`endif
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
